phase_sequencer: RTL



---
 rtl/phase_sequencer_if.sv | 24 ++
 rtl/phase_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/phase_sequencer_if.sv
// Sequencer bus: control requests in, phase/status/count out.
interface phase_sequencer_if #(
    parameter int ICOUNT_W = 16
);
    logic                RUN;
    logic                STEP;
    logic                HALT_REQ;
    logic [3:0]          OPCODE;
    logic [1:0]          PHASE;
    logic                BUSY;
    logic                HALTED;
    logic                INSTR_DONE;
    logic [ICOUNT_W-1:0] ICOUNT;

    modport master (
        output RUN, STEP, HALT_REQ, OPCODE,
        input  PHASE, BUSY, HALTED, INSTR_DONE, ICOUNT
    );

    modport slave (
        input  RUN, STEP, HALT_REQ, OPCODE,
        output PHASE, BUSY, HALTED, INSTR_DONE, ICOUNT
    );
endinterface

// File: rtl/phase_sequencer.sv
// RISCY instruction-cycle sequencer: FETCH/DECODE/EXECUTE/UPDATE
// with RAM wait states, run/step/halt control and retire counter.
module phase_sequencer #(
    parameter int WAIT_STATES = 1,
    parameter int ICOUNT_W    = 16
) (
    input logic             CLK,
    input logic             RST,
    phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam logic [2:0] WS_TERM = 3'(WAIT_STATES);
    localparam logic [3:0] OP_HLT  = 4'b1111;

    state_t              state, state_n;
    logic [2:0]          wcnt, wcnt_n;
    logic                step_mode, step_mode_n;
    logic                pend_halt;
    logic                run_q;
    logic                done;
    logic [ICOUNT_W-1:0] icount;
    logic                busy;

    assign busy = (state == S_FETCH) || (state == S_DECODE) ||
                  (state == S_EXECUTE) || (state == S_UPDATE);

    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        step_mode_n = step_mode;
        unique case (state)
            S_IDLE: begin
                if (bus.RUN) begin
                    state_n     = S_FETCH;
                    step_mode_n = 1'b0;
                end else if (bus.STEP) begin
                    state_n     = S_FETCH;
                    step_mode_n = 1'b1;
                end
            end
            S_FETCH: begin
                if (wcnt == WS_TERM) begin
                    state_n = S_DECODE;
                    wcnt_n  = 3'd0;
                end else begin
                    wcnt_n = wcnt + 3'd1;
                end
            end
            S_DECODE:  state_n = S_EXECUTE;
            S_EXECUTE: state_n = S_UPDATE;
            S_UPDATE: begin
                // A halt request arriving in UPDATE itself still stops here
                if (bus.OPCODE == OP_HLT)
                    state_n = S_HALT;
                else if (pend_halt || bus.HALT_REQ)
                    state_n = S_HALT;
                else if (step_mode || !bus.RUN)
                    state_n = S_IDLE;
                else
                    state_n = S_FETCH;
            end
            S_HALT: begin
                if (bus.STEP) begin
                    state_n     = S_FETCH;
                    step_mode_n = 1'b1;
                end else if (bus.RUN && !run_q) begin
                    state_n     = S_FETCH;
                    step_mode_n = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
                wcnt_n  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            wcnt      <= 3'd0;
            step_mode <= 1'b0;
            pend_halt <= 1'b0;
            run_q     <= 1'b0;
            done      <= 1'b0;
            icount    <= '0;
        end else begin
            state     <= state_n;
            wcnt      <= wcnt_n;
            step_mode <= step_mode_n;
            run_q     <= bus.RUN;
            done      <= (state == S_UPDATE);
            if (state_n == S_HALT)
                pend_halt <= 1'b0;
            else if (busy && bus.HALT_REQ)
                pend_halt <= 1'b1;
            if (state == S_UPDATE)
                icount <= icount + 1'b1;
        end
    end

    always_comb begin
        bus.PHASE = 2'd0;
        unique case (state)
            S_DECODE:  bus.PHASE = 2'd1;
            S_EXECUTE: bus.PHASE = 2'd2;
            S_UPDATE:  bus.PHASE = 2'd3;
            default:   bus.PHASE = 2'd0;
        endcase
    end

    assign bus.BUSY       = busy;
    assign bus.HALTED     = (state == S_HALT);
    assign bus.INSTR_DONE = done;
    assign bus.ICOUNT     = icount;
endmodule
